// File: rtl/riscv_soft_ctrl_pkg.sv
// Shared control definitions for the riscv_soft pipeline: opcodes, scoreboard entry layout
// and the instruction-field decode helpers used by the hazard unit.
package riscv_soft_ctrl_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam int unsigned FWD_SRC_REGFILE = 32'd0;

   typedef struct packed {
      logic       valid;
      logic       wr;
      logic [4:0] rd;
      logic       is_load;
   } sb_entry_t;

   function automatic logic [6:0] dec_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [4:0] dec_rd(input logic [31:0] instr);
      return instr[11:7];
   endfunction

   function automatic logic [4:0] dec_rs1(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] dec_rs2(input logic [31:0] instr);
      return instr[24:20];
   endfunction

   function automatic logic dec_writes_rd(input logic [31:0] instr);
      case (dec_opcode(instr))
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
         OPC_JAL, OPC_JALR, OPC_LOAD:           return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic dec_reads_rs1(input logic [31:0] instr);
      case (dec_opcode(instr))
         OPC_OP, OPC_OP_IMM, OPC_JALR,
         OPC_BRANCH, OPC_LOAD, OPC_STORE:       return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic dec_reads_rs2(input logic [31:0] instr);
      case (dec_opcode(instr))
         OPC_OP, OPC_BRANCH, OPC_STORE:         return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic dec_is_mem(input logic [31:0] instr);
      case (dec_opcode(instr))
         OPC_LOAD, OPC_STORE:                   return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_soft_fwd_match.sv
// Priority matcher for one source register against the post-EX scoreboard: youngest
// matching writer selects its stage, or flags a load-use hazard if its data is not back yet.
module riscv_soft_fwd_match
   import riscv_soft_ctrl_pkg::*;
#(
   parameter int  N_POST     = 2,
   parameter int  LOAD_STAGE = 2,
   localparam int FWD_W      = $clog2(N_POST + 1)
) (
   input  logic                   used,
   input  logic [4:0]             src,
   input  sb_entry_t [N_POST:1]   entries,
   output logic [FWD_W-1:0]       sel,
   output logic                   hazard
);

   logic hit_s;
   logic ready_s;

   // Oldest-to-youngest sweep so the lowest matching stage is the last one written
   always_comb begin
      sel     = FWD_W'(FWD_SRC_REGFILE);
      hazard  = 1'b0;
      hit_s   = 1'b0;
      ready_s = 1'b0;
      for (int k = N_POST; k >= 1; k--) begin
         hit_s   = used & entries[k].valid & entries[k].wr & (entries[k].rd == src);
         ready_s = ~entries[k].is_load | (k >= LOAD_STAGE);
         sel     = hit_s ? (ready_s ? FWD_W'(k) : FWD_W'(FWD_SRC_REGFILE)) : sel;
         hazard  = hit_s ? ~ready_s : hazard;
      end
   end

endmodule

// File: rtl/riscv_soft_hazard_unit.sv
// Hazard/forwarding controller: in-flight write scoreboard behind EX, operand forwarding
// selects, load-use / memory / redirect stalls, branch kill and the WB register commit.
module riscv_soft_hazard_unit
   import riscv_soft_ctrl_pkg::*;
#(
   parameter int  N_POST     = 2,
   parameter int  LOAD_STAGE = 2,
   localparam int FWD_W      = $clog2(N_POST + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst_valid_IF,
   input  logic [31:0]      instruction_EX,
   input  logic             branch_taken_EX,
   input  logic             icache_req_ready,
   input  logic             dcache_req_ready,
   input  logic             dcache_resp_valid,
   output logic             stall_IF,
   output logic             stall_EX,
   output logic             kill_IF,
   output logic             redirect_PIF,
   output logic [FWD_W-1:0] fwd_sel_1_EX,
   output logic [FWD_W-1:0] fwd_sel_2_EX,
   output logic             dcache_req_valid,
   output logic             wr_reg_WB,
   output logic [4:0]       rd_WB
);

   sb_entry_t [N_POST:1] sb_r;
   logic                 valid_ex_r;

   sb_entry_t ex_entry_s;
   logic      use_rs1_s;
   logic      use_rs2_s;
   logic      mem_op_s;
   logic      hazard_1_s;
   logic      hazard_2_s;
   logic      load_use_s;
   logic      stall_back_s;
   logic      stall_ex_s;
   logic      kill_s;

   // Decode the EX instruction into the entry it would push; rd is kept only for real writers
   always_comb begin
      ex_entry_s.valid   = valid_ex_r;
      ex_entry_s.wr      = valid_ex_r & dec_writes_rd(instruction_EX)
                         & (dec_rd(instruction_EX) != 5'd0);
      ex_entry_s.rd      = ex_entry_s.wr ? dec_rd(instruction_EX) : 5'd0;
      ex_entry_s.is_load = valid_ex_r & (dec_opcode(instruction_EX) == OPC_LOAD);
      use_rs1_s          = valid_ex_r & dec_reads_rs1(instruction_EX);
      use_rs2_s          = valid_ex_r & dec_reads_rs2(instruction_EX);
      mem_op_s           = valid_ex_r & dec_is_mem(instruction_EX);
   end

   riscv_soft_fwd_match #(.N_POST(N_POST), .LOAD_STAGE(LOAD_STAGE)) u_match_rs1 (
      .used    (use_rs1_s),
      .src     (dec_rs1(instruction_EX)),
      .entries (sb_r),
      .sel     (fwd_sel_1_EX),
      .hazard  (hazard_1_s)
   );

   riscv_soft_fwd_match #(.N_POST(N_POST), .LOAD_STAGE(LOAD_STAGE)) u_match_rs2 (
      .used    (use_rs2_s),
      .src     (dec_rs2(instruction_EX)),
      .entries (sb_r),
      .sel     (fwd_sel_2_EX),
      .hazard  (hazard_2_s)
   );

   // Stall and redirect combine; a pending load-use stall holds a taken branch back from killing
   always_comb begin
      stall_back_s = sb_r[LOAD_STAGE].valid & sb_r[LOAD_STAGE].is_load & ~dcache_resp_valid;
      load_use_s   = hazard_1_s | hazard_2_s;
      stall_ex_s   = valid_ex_r & (stall_back_s | load_use_s
                                   | (mem_op_s & ~dcache_req_ready)
                                   | (branch_taken_EX & ~icache_req_ready));
      kill_s       = valid_ex_r & branch_taken_EX & ~stall_ex_s;
   end

   // Scoreboard shift and EX valid; a stalled back end freezes every post-EX entry
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_r       <= '0;
         valid_ex_r <= 1'b0;
      end else begin
         if (!stall_back_s) begin
            sb_r[1] <= stall_ex_s ? sb_entry_t'('0) : ex_entry_s;
            for (int k = 2; k <= N_POST; k++) begin
               sb_r[k] <= sb_r[k-1];
            end
         end
         if (!stall_ex_s) begin
            valid_ex_r <= inst_valid_IF & ~kill_s;
         end
      end
   end

   // Outputs are decoded from registered state within the same cycle
   always_comb begin
      stall_EX         = stall_ex_s;
      stall_IF         = stall_ex_s;
      kill_IF          = kill_s;
      redirect_PIF     = kill_s;
      dcache_req_valid = mem_op_s & ~stall_back_s & ~load_use_s;
      wr_reg_WB        = sb_r[N_POST].valid & sb_r[N_POST].wr & ~stall_back_s;
      rd_WB            = sb_r[N_POST].rd;
   end

endmodule
